// File: rtl/pwm_chain_counter.sv
`default_nettype none
// ============================================================================
// pwm_chain_counter : timebase counter for one PWM chain (up/down/triangle)
// Revision 1.0
// ============================================================================
module pwm_chain_counter #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic                     i_tick,
    input  logic [15:0]              i_timebase_shift,
    input  logic [2:0]               i_counter_mode,
    input  logic [COUNTER_WIDTH-1:0] i_counter_start_data,
    input  logic [COUNTER_WIDTH-1:0] i_counter_stop_data,
    output logic [COUNTER_WIDTH-1:0] o_counter_out,
    output logic                     o_direction,
    output logic                     o_period_end,
    output logic                     o_counter_running
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [2:0]               c_MODE_UP   = 3'd0;
    localparam logic [2:0]               c_MODE_DOWN = 3'd1;
    localparam logic [2:0]               c_MODE_TRI  = 3'd2;
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_ONE   = COUNTER_WIDTH'(1);
    localparam logic [15:0]              c_SHIFT_ONE = 16'd1;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [2:0]               r_cfg_mode;
    logic [2:0]               w_cfg_mode_next;
    logic [COUNTER_WIDTH-1:0] r_cfg_start;
    logic [COUNTER_WIDTH-1:0] w_cfg_start_next;
    logic [COUNTER_WIDTH-1:0] r_cfg_stop;
    logic [COUNTER_WIDTH-1:0] w_cfg_stop_next;
    logic [15:0]              r_shift_cnt;
    logic [15:0]              w_shift_cnt_next;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_count_next;
    logic                     r_dir;
    logic                     w_dir_next;
    logic                     r_period_end;
    logic                     w_period_end_next;
    logic                     r_running;
    logic                     w_running_next;

    logic                     w_start_ok;
    logic [COUNTER_WIDTH-1:0] w_in_first;
    logic [COUNTER_WIDTH-1:0] w_cfg_first;
    logic [COUNTER_WIDTH-1:0] w_step_value;
    logic                     w_step_dir;
    logic                     w_step_wrap;
    logic                     w_stop_pending;

    assign w_start_ok = i_enable
                        && (i_counter_stop_data > i_counter_start_data)
                        && (i_counter_mode <= c_MODE_TRI);

    // Direct start takes its first value from the inputs being latched this edge.
    assign w_in_first  = (i_counter_mode == c_MODE_DOWN) ? i_counter_stop_data
                                                         : i_counter_start_data;
    assign w_cfg_first = (r_cfg_mode == c_MODE_DOWN) ? r_cfg_stop : r_cfg_start;

    // A low enable marks a pending stop and a high enable cancels it, so at a
    // boundary the current enable sample decides; re-assertion there wins.
    assign w_stop_pending = ~i_enable;

    // Value loaded by one tick in RUN, and whether that load starts a new period.
    always_comb begin
        w_step_value = r_count;
        w_step_dir   = r_dir;
        w_step_wrap  = 1'b0;
        case (r_cfg_mode)
            c_MODE_UP: begin
                if (r_count == r_cfg_stop) begin
                    w_step_value = r_cfg_start;
                    w_step_wrap  = 1'b1;
                end else begin
                    w_step_value = r_count + c_CNT_ONE;
                end
            end
            c_MODE_DOWN: begin
                if (r_count == r_cfg_start) begin
                    w_step_value = r_cfg_stop;
                    w_step_wrap  = 1'b1;
                end else begin
                    w_step_value = r_count - c_CNT_ONE;
                end
            end
            c_MODE_TRI: begin
                if (!r_dir) begin
                    if (r_count == r_cfg_stop) begin
                        w_step_value = r_cfg_stop - c_CNT_ONE;
                        w_step_dir   = 1'b1;
                    end else begin
                        w_step_value = r_count + c_CNT_ONE;
                    end
                end else begin
                    w_step_value = r_count - c_CNT_ONE;
                end
                // With stop == start+1 the peak tick lands directly on start.
                if (w_step_dir && (w_step_value == r_cfg_start)) begin
                    w_step_dir  = 1'b0;
                    w_step_wrap = 1'b1;
                end
            end
            default: begin
                w_step_value = r_count;
            end
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_cfg_mode_next   = r_cfg_mode;
        w_cfg_start_next  = r_cfg_start;
        w_cfg_stop_next   = r_cfg_stop;
        w_shift_cnt_next  = r_shift_cnt;
        w_count_next      = r_count;
        w_dir_next        = r_dir;
        w_period_end_next = 1'b0;
        w_running_next    = r_running;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_cfg_mode_next  = i_counter_mode;
                    w_cfg_start_next = i_counter_start_data;
                    w_cfg_stop_next  = i_counter_stop_data;
                    w_running_next   = 1'b1;
                    if (i_timebase_shift != 16'd0) begin
                        w_state_next     = S_SHIFT;
                        w_shift_cnt_next = i_timebase_shift - c_SHIFT_ONE;
                    end else begin
                        w_state_next      = S_RUN;
                        w_count_next      = w_in_first;
                        w_dir_next        = (i_counter_mode == c_MODE_DOWN);
                        w_period_end_next = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (!i_enable) begin
                    w_state_next   = S_IDLE;
                    w_running_next = 1'b0;
                end else if (r_shift_cnt == 16'd0) begin
                    w_state_next      = S_RUN;
                    w_count_next      = w_cfg_first;
                    w_dir_next        = (r_cfg_mode == c_MODE_DOWN);
                    w_period_end_next = 1'b1;
                end else begin
                    w_shift_cnt_next = r_shift_cnt - c_SHIFT_ONE;
                end
            end
            S_RUN: begin
                if (i_tick) begin
                    w_count_next      = w_step_value;
                    w_dir_next        = w_step_dir;
                    w_period_end_next = w_step_wrap;
                    if (w_step_wrap && w_stop_pending) begin
                        w_state_next   = S_IDLE;
                        w_running_next = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_running_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cfg_mode   <= 3'd0;
            r_cfg_start  <= '0;
            r_cfg_stop   <= '0;
            r_shift_cnt  <= 16'd0;
            r_count      <= '0;
            r_dir        <= 1'b0;
            r_period_end <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cfg_mode   <= w_cfg_mode_next;
            r_cfg_start  <= w_cfg_start_next;
            r_cfg_stop   <= w_cfg_stop_next;
            r_shift_cnt  <= w_shift_cnt_next;
            r_count      <= w_count_next;
            r_dir        <= w_dir_next;
            r_period_end <= w_period_end_next;
            r_running    <= w_running_next;
        end
    end

    assign o_counter_out     = r_count;
    assign o_direction       = r_dir;
    assign o_period_end      = r_period_end;
    assign o_counter_running = r_running;

endmodule
`default_nettype wire

// File: tb/tb_pwm_chain_counter.sv
`default_nettype none
// tb_pwm_chain_counter : directed and randomized checks of pwm_chain_counter
// against a model that walks a precomputed list of one period's values.
module tb_pwm_chain_counter;

    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          tick;
    logic [15:0]   shift;
    logic [2:0]    mode;
    logic [CW-1:0] start_v;
    logic [CW-1:0] stop_v;
    wire  [CW-1:0] out_v;
    wire           dir_v;
    wire           pe_v;
    wire           run_v;

    int total = 0;
    int bad   = 0;

    // Model: 0 idle, 1 waiting out the shift, 2 running through m_vals.
    int            m_state      = 0;
    int            m_shift_left = 0;
    int            m_idx        = 0;
    int            m_vals[$];
    bit            m_dirs[$];
    logic [CW-1:0] m_out = '0;
    logic          m_dir = 1'b0;
    logic          m_pe  = 1'b0;
    logic          m_run = 1'b0;

    wire [CW+2:0] obs   = {run_v, pe_v, dir_v, out_v};
    wire [CW+2:0] exp_m = {m_run, m_pe, m_dir, m_out};

    pwm_chain_counter #(.COUNTER_WIDTH(CW)) dut (
        .clock                (clock),
        .reset                (reset),
        .i_enable             (enable),
        .i_tick               (tick),
        .i_timebase_shift     (shift),
        .i_counter_mode       (mode),
        .i_counter_start_data (start_v),
        .i_counter_stop_data  (stop_v),
        .o_counter_out        (out_v),
        .o_direction          (dir_v),
        .o_period_end         (pe_v),
        .o_counter_running    (run_v)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic build_period(input int md, input int s, input int e);
        m_vals.delete();
        m_dirs.delete();
        if (md == 0) begin
            for (int v = s; v <= e; v++) begin m_vals.push_back(v); m_dirs.push_back(1'b0); end
        end else if (md == 1) begin
            for (int v = e; v >= s; v--) begin m_vals.push_back(v); m_dirs.push_back(1'b1); end
        end else begin
            for (int v = s; v <= e; v++) begin m_vals.push_back(v); m_dirs.push_back(1'b0); end
            for (int v = e - 1; v > s; v--) begin m_vals.push_back(v); m_dirs.push_back(1'b1); end
        end
    endtask

    task automatic enter_run();
        m_state = 2;
        m_idx   = 0;
        m_out   = CW'(m_vals[0]);
        m_dir   = m_dirs[0];
        m_pe    = 1'b1;
    endtask

    task automatic model_advance();
        m_pe = 1'b0;
        if (!reset) begin
            m_state = 0; m_out = '0; m_dir = 1'b0; m_run = 1'b0; m_idx = 0;
        end else begin
            case (m_state)
                0: if (enable && (stop_v > start_v) && (mode <= 3'd2)) begin
                    build_period(int'(mode), int'(start_v), int'(stop_v));
                    m_run = 1'b1;
                    if (shift == 16'd0) enter_run();
                    else begin m_state = 1; m_shift_left = int'(shift); end
                end
                1: if (!enable) begin
                    m_state = 0; m_run = 1'b0;
                end else begin
                    m_shift_left--;
                    if (m_shift_left == 0) enter_run();
                end
                default: if (tick) begin
                    m_idx = (m_idx + 1) % m_vals.size();
                    m_out = CW'(m_vals[m_idx]);
                    m_dir = m_dirs[m_idx];
                    if (m_idx == 0) begin
                        m_pe = 1'b1;
                        if (!enable) begin m_state = 0; m_run = 1'b0; end
                    end
                end
            endcase
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled at negedge.
    task automatic cyc();
        @(posedge clock);
        model_advance();
        @(negedge clock);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        reset  = 1'b0;
        cyc();
        reset  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; tick = 1'b1; shift = 16'd0;
        mode = 3'd0; start_v = 16'd1; stop_v = 16'd4;
        repeat (3) cyc();
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_hold: got %h (run,pe,dir,out) expected 0", obs);
        end
        enable = 1'b0; reset = 1'b1;
        repeat (2) cyc();
        total++;
        if (obs !== '0 || obs !== exp_m) begin
            bad++; $display("FAIL reset_idle: got %h expected 0 (model %h)", obs, exp_m);
        end
    endtask

    task automatic test_mode0_basic();
        int exp_out[5];
        bit exp_pe[5];
        exp_out = '{2, 3, 4, 5, 2};
        exp_pe  = '{1, 0, 0, 0, 1};
        mode = 3'd0; start_v = 16'd2; stop_v = 16'd5; shift = 16'd0; tick = 1'b1; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            total++;
            if (out_v !== exp_out[k] || pe_v !== exp_pe[k] || run_v !== 1'b1 || dir_v !== 1'b0) begin
                bad++; $display("FAIL mode0_seq[%0d]: got out=%0d pe=%b run=%b dir=%b expected out=%0d pe=%b run=1 dir=0",
                                k, out_v, pe_v, run_v, dir_v, exp_out[k], exp_pe[k]);
            end
            total++;
            if (obs !== exp_m) begin
                bad++; $display("FAIL mode0_model[%0d]: got %h expected %h", k, obs, exp_m);
            end
        end
        go_idle();
    endtask

    task automatic test_mode2_half_tick();
        int seq[7];
        bit dseq[7];
        bit pseq[7];
        bit want_pe;
        seq  = '{0, 1, 2, 3, 2, 1, 0};
        dseq = '{0, 0, 0, 0, 1, 1, 0};
        pseq = '{1, 0, 0, 0, 0, 0, 1};
        mode = 3'd2; start_v = 16'd0; stop_v = 16'd3; shift = 16'd0; enable = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick = (k % 2 == 0);
            cyc();
            want_pe = pseq[k/2] && (k % 2 == 0);
            total++;
            if (out_v !== seq[k/2] || dir_v !== dseq[k/2] || pe_v !== want_pe) begin
                bad++; $display("FAIL tri_seq[%0d]: got out=%0d dir=%b pe=%b expected out=%0d dir=%b pe=%b",
                                k, out_v, dir_v, pe_v, seq[k/2], dseq[k/2], want_pe);
            end
            total++;
            if (obs !== exp_m) begin
                bad++; $display("FAIL tri_model[%0d]: got %h expected %h", k, obs, exp_m);
            end
        end
        go_idle();
    endtask

    task automatic test_mode1_shift();
        int after[3];
        bit ape[3];
        after = '{11, 10, 12};
        ape   = '{0, 0, 1};
        mode = 3'd1; start_v = 16'd10; stop_v = 16'd12; shift = 16'd4; tick = 1'b1; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++;
            if (run_v !== 1'b1 || pe_v !== 1'b0 || out_v !== 16'd0 || obs !== exp_m) begin
                bad++; $display("FAIL shift_wait[%0d]: got run=%b pe=%b out=%0d expected run=1 pe=0 out=0",
                                k, run_v, pe_v, out_v);
            end
        end
        cyc();
        total++;
        if (out_v !== 16'd12 || pe_v !== 1'b1 || dir_v !== 1'b1 || run_v !== 1'b1) begin
            bad++; $display("FAIL shift_entry: got out=%0d pe=%b dir=%b run=%b expected out=12 pe=1 dir=1 run=1",
                            out_v, pe_v, dir_v, run_v);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++;
            if (out_v !== after[k] || pe_v !== ape[k] || dir_v !== 1'b1 || obs !== exp_m) begin
                bad++; $display("FAIL down_seq[%0d]: got out=%0d pe=%b dir=%b expected out=%0d pe=%b dir=1",
                                k, out_v, pe_v, dir_v, after[k], ape[k]);
            end
        end
        go_idle();
    endtask

    task automatic test_stop_request();
        mode = 3'd0; start_v = 16'd0; stop_v = 16'd7; shift = 16'd0; tick = 1'b1; enable = 1'b1;
        repeat (4) cyc();
        total++;
        if (out_v !== 16'd3) begin
            bad++; $display("FAIL stop_pre: got out=%0d expected 3", out_v);
        end
        enable = 1'b0; start_v = 16'd2; stop_v = 16'd4;
        for (int v = 4; v <= 7; v++) begin
            cyc();
            total++;
            if (out_v !== v || run_v !== 1'b1 || pe_v !== 1'b0 || obs !== exp_m) begin
                bad++; $display("FAIL stop_drain[%0d]: got out=%0d run=%b pe=%b expected out=%0d run=1 pe=0",
                                v, out_v, run_v, pe_v, v);
            end
        end
        cyc();
        total++;
        if (out_v !== 16'd0 || pe_v !== 1'b1 || run_v !== 1'b0) begin
            bad++; $display("FAIL stop_boundary: got out=%0d pe=%b run=%b expected out=0 pe=1 run=0",
                            out_v, pe_v, run_v);
        end
        for (int k = 0; k < 3; k++) begin
            start_v = 16'(k + 1); stop_v = 16'(k + 9);
            cyc();
            total++;
            if (out_v !== 16'd0 || run_v !== 1'b0 || pe_v !== 1'b0 || obs !== exp_m) begin
                bad++; $display("FAIL stop_idle[%0d]: got out=%0d run=%b pe=%b expected out=0 run=0 pe=0",
                                k, out_v, run_v, pe_v);
            end
        end
        start_v = 16'd2; stop_v = 16'd4; enable = 1'b1;
        cyc();
        total++;
        if (out_v !== 16'd2 || pe_v !== 1'b1 || run_v !== 1'b1) begin
            bad++; $display("FAIL stop_restart: got out=%0d pe=%b run=%b expected out=2 pe=1 run=1",
                            out_v, pe_v, run_v);
        end
        go_idle();
    endtask

    task automatic test_enable_reassert();
        mode = 3'd0; start_v = 16'd0; stop_v = 16'd3; shift = 16'd0; tick = 1'b1; enable = 1'b1;
        cyc(); cyc();
        enable = 1'b0;
        cyc(); cyc();
        enable = 1'b1;
        cyc();
        total++;
        if (out_v !== 16'd0 || pe_v !== 1'b1 || run_v !== 1'b1 || obs !== exp_m) begin
            bad++; $display("FAIL reassert_boundary: got out=%0d pe=%b run=%b expected out=0 pe=1 run=1",
                            out_v, pe_v, run_v);
        end
        cyc();
        total++;
        if (out_v !== 16'd1 || pe_v !== 1'b0 || run_v !== 1'b1) begin
            bad++; $display("FAIL reassert_continue: got out=%0d pe=%b run=%b expected out=1 pe=0 run=1",
                            out_v, pe_v, run_v);
        end
        cyc(); cyc();
        enable = 1'b0;
        cyc();
        total++;
        if (out_v !== 16'd0 || pe_v !== 1'b1 || run_v !== 1'b0 || obs !== exp_m) begin
            bad++; $display("FAIL late_drop_stop: got out=%0d pe=%b run=%b expected out=0 pe=1 run=0",
                            out_v, pe_v, run_v);
        end
        go_idle();
    endtask

    task automatic test_invalid_cfg();
        int exp_out[3];
        bit exp_pe[3];
        exp_out = '{5, 6, 5};
        exp_pe  = '{1, 0, 1};
        mode = 3'd0; start_v = 16'd5; stop_v = 16'd5; shift = 16'd0; tick = 1'b1; enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin mode = 3'd5; stop_v = 16'd6; end
            cyc();
            total++;
            if (run_v !== 1'b0 || out_v !== 16'd0 || pe_v !== 1'b0 || obs !== exp_m) begin
                bad++; $display("FAIL invalid_idle[%0d]: got run=%b out=%0d pe=%b expected run=0 out=0 pe=0",
                                k, run_v, out_v, pe_v);
            end
        end
        mode = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++;
            if (out_v !== exp_out[k] || pe_v !== exp_pe[k] || run_v !== 1'b1) begin
                bad++; $display("FAIL valid_after[%0d]: got out=%0d pe=%b run=%b expected out=%0d pe=%b run=1",
                                k, out_v, pe_v, run_v, exp_out[k], exp_pe[k]);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        mode = 3'd0; start_v = 16'd3; stop_v = 16'd9; shift = 16'd0; tick = 1'b1; enable = 1'b1;
        repeat (4) cyc();
        reset = 1'b0;
        cyc();
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_run: got %h expected 0", obs);
        end
        reset = 1'b1;
        cyc();
        total++;
        if (out_v !== 16'd3 || pe_v !== 1'b1 || run_v !== 1'b1 || dir_v !== 1'b0) begin
            bad++; $display("FAIL reset_run_restart: got out=%0d pe=%b run=%b dir=%b expected out=3 pe=1 run=1 dir=0",
                            out_v, pe_v, run_v, dir_v);
        end
        reset = 1'b0; shift = 16'd5;
        cyc();
        reset = 1'b1;
        cyc(); cyc(); cyc();
        reset = 1'b0;
        cyc();
        total++;
        if (obs !== '0 || obs !== exp_m) begin
            bad++; $display("FAIL reset_shift: got %h expected 0", obs);
        end
        reset = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++;
            if (run_v !== 1'b1 || pe_v !== 1'b0 || out_v !== 16'd0) begin
                bad++; $display("FAIL reset_shift_wait[%0d]: got run=%b pe=%b out=%0d expected run=1 pe=0 out=0",
                                k, run_v, pe_v, out_v);
            end
        end
        cyc();
        total++;
        if (out_v !== 16'd3 || pe_v !== 1'b1 || run_v !== 1'b1 || obs !== exp_m) begin
            bad++; $display("FAIL reset_shift_restart: got out=%0d pe=%b run=%b expected out=3 pe=1 run=1",
                            out_v, pe_v, run_v);
        end
        go_idle();
    endtask

    task automatic rand_cfg();
        int span;
        span = $urandom_range(0, 10);
        if ($urandom_range(0, 3) == 0) start_v = 16'(16'hFFFF - span);
        else                           start_v = 16'($urandom_range(0, 65535 - span));
        stop_v = start_v + 16'(span);
        if ($urandom_range(0, 9) == 0) begin
            stop_v  = start_v;
            start_v = start_v + 16'd1;
        end
        mode  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        shift = 16'($urandom_range(0, 5));
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            rand_cfg();
            enable = 1'b1;
            reset  = 1'b1;
            for (int c = 0; c < 160; c++) begin
                tick = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) enable = ~enable;
                reset = ($urandom_range(0, 299) != 0);
                if ($urandom_range(0, 3) == 0) rand_cfg();
                cyc();
                total++;
                if (obs !== exp_m) begin
                    bad++; $display("FAIL random[%0d.%0d]: got run,pe,dir,out=%h expected %h", n, c, obs, exp_m);
                end
            end
        end
        go_idle();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; tick = 1'b0; shift = 16'd0;
        mode = 3'd0; start_v = '0; stop_v = '0;
        @(negedge clock);
        test_reset();
        test_mode0_basic();
        test_mode2_half_tick();
        test_mode1_shift();
        test_stop_request();
        test_enable_reassert();
        test_invalid_cfg();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
